// File: rtl/pmem_line_responder.sv
// Line-granular memory responder for the pmem_read/pmem_write/pmem_resp handshake.
// Optional PMEM_STATS_EN adds saturating read_count/write_count completion counters.
module pmem_line_responder #(
  parameter int LINE_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 32,
  parameter int OFFSET_BITS   = 5,
  parameter int INDEX_BITS    = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  proto_err
`ifdef PMEM_STATS_EN
  ,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic                  r_is_write;
  logic [INDEX_BITS-1:0] r_index;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [LINE_WIDTH-1:0] r_mem [2**INDEX_BITS];

  logic [INDEX_BITS-1:0] w_req_index;
  logic [INDEX_BITS-1:0] w_rd_index;
  logic [7:0]            w_lat_m1;
  logic                  w_req;
  logic                  w_req_dropped;
  logic                  w_rd_fire;
  logic                  w_unused;

  assign w_req_index   = pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_unused      = ^{pmem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                           pmem_address[OFFSET_BITS-1:0]};
  assign w_req         = pmem_read | pmem_write;
  assign w_lat_m1      = pmem_write ? 8'(WRITE_LATENCY - 1) : 8'(READ_LATENCY - 1);
  assign w_req_dropped = r_is_write ? !pmem_write : !pmem_read;

  // The array read is launched on the edge that enters RESP so data is valid during RESP.
  assign w_rd_fire  = ((r_state == IDLE) && pmem_read && !pmem_write && (READ_LATENCY == 1)) ||
                      ((r_state == BUSY) && !r_is_write && !w_req_dropped && (r_cnt == 8'd1));
  assign w_rd_index = (r_state == IDLE) ? w_req_index : r_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_is_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_write <= pmem_write;
            r_index    <= w_req_index;
            r_wdata    <= pmem_wdata;
            if (pmem_write && pmem_read) r_err <= 1'b1;
            if (w_lat_m1 == 8'd0) begin
              r_state <= RESP;
            end else begin
              r_state <= BUSY;
              r_cnt   <= w_lat_m1;
            end
          end
        end
        BUSY: begin
          if (w_req_dropped) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_err   <= 1'b1;
          end else if (r_cnt == 8'd1) begin
            r_state <= RESP;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_fire) begin
      r_rdata <= r_mem[w_rd_index];
    end
  end

  // Array contents survive reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == RESP) && r_is_write) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  assign pmem_rdata = r_rdata;
  assign pmem_resp  = (r_state == RESP);
  assign proto_err  = r_err;

`ifdef PMEM_STATS_EN
  logic [31:0] r_read_count;
  logic [31:0] r_write_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_count  <= 32'd0;
      r_write_count <= 32'd0;
    end else if (r_state == RESP) begin
      if (r_is_write && (r_write_count != 32'hFFFF_FFFF)) r_write_count <= r_write_count + 32'd1;
      if (!r_is_write && (r_read_count != 32'hFFFF_FFFF)) r_read_count <= r_read_count + 32'd1;
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: the driver pushes expected responses from a
// line-array model, an independent negedge monitor pops and checks them.
module tb_pmem_line_responder;

  localparam int LW = 256;
  localparam int RL = 4;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [31:0]   pmem_address = '0;
  logic [LW-1:0] pmem_wdata = '0;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          proto_err;
`ifdef PMEM_STATS_EN
  logic [31:0]   read_count;
  logic [31:0]   write_count;
`endif

  pmem_line_responder #(
    .LINE_WIDTH(LW), .ADDR_WIDTH(32), .OFFSET_BITS(5), .INDEX_BITS(8),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .proto_err(proto_err)
`ifdef PMEM_STATS_EN
    , .read_count(read_count), .write_count(write_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    bit          known;
    logic [LW-1:0] data;
    int          cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [LW-1:0] m_mem [256];
  bit            m_known [256];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            n_rd = 0;
  int            n_wr = 0;
  bit            exp_err = 1'b0;
  bit            mon_en = 1'b0;
  logic [LW-1:0] last_rd = '0;
  bit            last_known = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: every response must match the head of the scoreboard; rdata must hold otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (pmem_resp && sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_resp cyc=%0d got resp=1 want resp=0", cyc);
      end else if (pmem_resp) begin
        e = sbq.pop_front();
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL resp_cycle got cyc=%0d want cyc=%0d", cyc, e.cyc);
        end
        if (e.is_rd) begin
          if (e.known) begin
            total++;
            if (pmem_rdata !== e.data) begin
              bad++;
              $display("FAIL read_data cyc=%0d got %h want %h", cyc, pmem_rdata, e.data);
            end
          end
          last_rd    = e.data;
          last_known = e.known;
          $display("resp read  cyc=%0d data=%h", cyc, pmem_rdata);
        end else begin
          $display("resp write cyc=%0d", cyc);
        end
      end
      if (!(pmem_resp && sbq.size() >= 0 && e.is_rd) && last_known && !pmem_resp) begin
        total++;
        if (pmem_rdata !== last_rd) begin
          bad++;
          $display("FAIL rdata_hold cyc=%0d got %h want %h", cyc, pmem_rdata, last_rd);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_req();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_req();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    last_rd    = '0;
    last_known = 1'b1;
    exp_err    = 1'b0;
    n_rd       = 0;
    n_wr       = 0;
    sbq.delete();
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [LW-1:0] d, input bit push);
    exp_t e;
    int   idx;
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = a;
    pmem_wdata   = d;
    if (push) begin
      idx     = int'(a[12:5]);
      e.is_rd = rd && !wr;
      e.cyc   = cyc + (wr ? WL : RL);
      e.data  = '0;
      e.known = 1'b0;
      if (wr) begin
        m_mem[idx]   = d;
        m_known[idx] = 1'b1;
        n_wr++;
        if (rd) exp_err = 1'b1;
      end else begin
        e.data  = m_mem[idx];
        e.known = m_known[idx];
        n_rd++;
      end
      sbq.push_back(e);
      $display("req %s addr=%h cyc=%0d", wr ? (rd ? "both " : "write") : "read ", a, cyc);
    end
  endtask

  task automatic wait_resp();
    bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (pmem_resp) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL resp_timeout got resp=0 want resp=1 within 300 cycles");
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [LW-1:0] a5;
    logic [LW-1:0] one;
    logic [31:0]   a;
    int            op;
    a5  = {32{8'hA5}};
    one = '0;
    one[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end

    do_reset();
    mon_en = 1'b1;
    chk("reset_resp", LW'(pmem_resp), '0);
    chk("reset_rdata", pmem_rdata, '0);
    chk("reset_err", LW'(proto_err), '0);

    // Write then read the same line, then an aliased address.
    drive(1'b1, 1'b0, 32'h0000_0040, a5, 1'b1); wait_resp(); idle_req(); tick(1);
    drive(1'b0, 1'b1, 32'h0000_0040, '0, 1'b1); wait_resp(); idle_req(); tick(1);
    chk("err_after_clean", LW'(proto_err), '0);
    drive(1'b0, 1'b1, 32'h0000_2040, '0, 1'b1); wait_resp(); idle_req(); tick(1);

    // Back-to-back: switch request right after the response edge.
    drive(1'b1, 1'b0, 32'h0000_0060, rand_line(), 1'b1); wait_resp();
    drive(1'b0, 1'b1, 32'h0000_0060, '0, 1'b1); wait_resp(); idle_req(); tick(2);

    // Both requests asserted: write wins, flag sticks.
    drive(1'b1, 1'b1, 32'h0000_0080, one, 1'b1); wait_resp(); idle_req(); tick(1);
    chk("both_err", LW'(proto_err), LW'(1));
    drive(1'b0, 1'b1, 32'h0000_0080, '0, 1'b1); wait_resp(); idle_req(); tick(1);

    // Dropped write during BUSY aborts without commit.
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0040, rand_line(), 1'b0);
    tick(3);
    idle_req();
    tick(8);
    chk("abort_err", LW'(proto_err), LW'(1));
    drive(1'b0, 1'b1, 32'h0000_0040, '0, 1'b1); wait_resp(); idle_req(); tick(1);

    // Reset in the middle of BUSY aborts without commit.
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0040, rand_line(), 1'b0);
    tick(2);
    do_reset();
    chk("rst_busy_resp", LW'(pmem_resp), '0);
    chk("rst_busy_rdata", pmem_rdata, '0);
    chk("rst_busy_err", LW'(proto_err), '0);
    tick(6);
    drive(1'b0, 1'b1, 32'h0000_0040, '0, 1'b1); wait_resp(); idle_req(); tick(1);

    // Random traffic over a few lines with random upper/offset bits and spacing.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 7)) << 5) | ($urandom & 32'h1F);
      if (op == 0)      drive(1'b1, 1'b1, a, rand_line(), 1'b1);
      else if (op <= 4) drive(1'b1, 1'b0, a, rand_line(), 1'b1);
      else              drive(1'b0, 1'b1, a, '0, 1'b1);
      wait_resp();
      if ($urandom_range(0, 2) != 0) begin
        idle_req();
        tick($urandom_range(0, 2));
      end
    end
    idle_req();
    tick(2);
    chk("random_err", LW'(proto_err), LW'(exp_err));

`ifdef PMEM_STATS_EN
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_0040, '0, 1'b1); wait_resp(); idle_req(); tick(1);
    drive(1'b1, 1'b0, 32'h0000_0060, rand_line(), 1'b1); wait_resp(); idle_req(); tick(1);
    drive(1'b1, 1'b0, 32'h0000_0080, rand_line(), 1'b0); tick(2); idle_req(); tick(6);
    drive(1'b0, 1'b1, 32'h0000_0060, '0, 1'b1); wait_resp(); idle_req(); tick(1);
    drive(1'b0, 1'b1, 32'h0000_0080, '0, 1'b1); wait_resp(); idle_req(); tick(2);
    chk("read_count", LW'(read_count), LW'(n_rd));
    chk("write_count", LW'(write_count), LW'(n_wr));
`endif

    tick(4);
    chk("scoreboard_empty", LW'(sbq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Memory-side responder for the cache-to-physical-memory line protocol (pmem_read / pmem_write / pmem_resp).
- Answers whole-line read and write requests from a cache or victim-cache controller.
- Backed by an on-chip line array with programmable response latency.
- Used as the synthesizable stand-in for physical memory on board builds and as the memory endpoint in cache-level simulation.

Parameters:
- LINE_WIDTH, 256, bits per cache line / transfer.
- ADDR_WIDTH, 32, request address width.
- OFFSET_BITS, 5, low address bits ignored (byte offset within line).
- INDEX_BITS, 8, address bits above offset selecting a line; array depth 2**INDEX_BITS.
- READ_LATENCY, 4, cycles from request sample to pmem_resp for reads; legal range 1..255.
- WRITE_LATENCY, 4, same for writes; legal range 1..255.

Ports:
- clk  input  1  clock, all logic posedge.
- rst  input  1  synchronous active-high reset.
- pmem_read  input  1  line read request, held by initiator until pmem_resp.
- pmem_write  input  1  line write request, held by initiator until pmem_resp.
- pmem_address  input  ADDR_WIDTH  line address.
- pmem_wdata  input  LINE_WIDTH  write line data.
- pmem_rdata  output  LINE_WIDTH  read line data.
- pmem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock domain, clk; reset is synchronous and active-high (rst).
- Reset: state IDLE; counter 0; pmem_resp=0; pmem_rdata=0; proto_err=0. Array contents are not cleared. Reset mid-transaction aborts it, and no array write occurs.
- Line index is pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]. Upper address bits are ignored, so addresses alias modulo the array size.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If pmem_write or pmem_read is high at posedge, latch op, index and wdata.
  - Load counter with LATENCY-1 for the op.
  - Go to BUSY, or go straight to RESP when LATENCY=1.
  - If both are high: write wins and proto_err is set.
- BUSY:
  - Counter decrements each cycle; at 0, go to RESP.
  - If the latched op's request line drops while in BUSY: abort to IDLE, no commit, proto_err set.
  - Address/wdata changes during BUSY are ignored; the latched values are used.
- RESP:
  - pmem_resp=1 for exactly this cycle, then go to IDLE unconditionally.
  - Read: pmem_rdata is driven with array[index] during this cycle and holds that value until the next read RESP.
  - Write: array[index] <= latched wdata at the end of this cycle.
- Latency: request first high in cycle T (state IDLE) gives pmem_resp in cycle T+LATENCY.
- Back-to-back:
  - The initiator's request is still high during RESP; it is not re-sampled.
  - A new request seen in the IDLE cycle after RESP starts immediately. Minimum request spacing is LATENCY+1 cycles.
  - Write immediately followed by read of the same line returns the new data.
- Read-during-write is impossible, since only one transaction is in flight.
- proto_err clears only on rst.

Optional Feature:
- Macro PMEM_STATS_EN.
- Defined: adds outputs read_count[31:0] and write_count[31:0].
  - Each increments on completed RESP of its type and saturates at 0xFFFFFFFF.
  - Aborted transactions are not counted.
  - Both reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write 0xA5A5… at addr 0x0000_0040, then read 0x0000_0040 → resp exactly 4 cycles after each request; rdata=0xA5A5… in the read RESP cycle; proto_err=0.
- Read 0x0000_2040 after the previous write → returns 0xA5A5… (index aliasing, INDEX_BITS=8).
- Back-to-back write then read to the same line, initiator switching request on resp edge → second request accepted the cycle after RESP; read returns the written data; no duplicate resp.
- Assert pmem_read and pmem_write together at addr 0x80 with wdata=0x1 → proto_err=1; write performed; a later read of 0x80 returns 0x1.
- Drop pmem_write 2 cycles into BUSY → no resp; return to IDLE; proto_err=1; a later read of that line returns the old data. Separately, assert rst mid-BUSY → resp stays 0, rdata=0, array unchanged.
- With PMEM_STATS_EN: 3 reads plus 2 writes, one of them aborted → read_count=3, write_count=1.
